rv32i_run_ctrl: RTL and testbench
=================================

// Module: rv32i_run_ctrl
// PURPOSE
//  Debug run controller between the board keys and the rv32i core.
//  - Debounces NKEYS push-buttons and drives the core clock-enable (cpu_en).
//  - Modes: halted, single-step, free-run.
//  - Stops on: breakpoint address, EBREAK/ECALL, or a retired-instruction limit.
//  - Makes the step/trace flow used in simulation available in hardware.
// PARAMETERS
//  ADDR_W     16  width of instr_addr / bp_addr
//  NKEYS      2   debounced keys; key[0]=STEP, key[1]=RUN/HALT toggle, others spare
//  DEBOUNCE   4   consecutive stable synced samples before a key level is accepted (>=2)
//  CNT_W      8   width of retired counter and step_limit
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  key          in   NKEYS   raw asynchronous buttons, active-high
//  instr_addr   in   ADDR_W  PC of the instruction the core executes when cpu_en=1
//  instruction  in   32      instruction word at instr_addr
//  bp_en        in   1       breakpoint enable
//  bp_addr      in   ADDR_W  breakpoint PC
//  step_limit   in   CNT_W   retire limit; 0 = unlimited
//  cpu_en       out  1       core clock-enable; one retired instruction per high cycle
//  halted       out  1       1 in HALT or DONE
//  done         out  1       sticky end-of-program flag
//  halt_cause   out  2       0 key/reset, 1 breakpoint, 2 EBREAK, 3 ECALL/limit
//  retired      out  CNT_W   instructions retired since reset; saturates at all-ones
//  key_pulse    out  NKEYS   one-cycle pulse per debounced rising edge
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=HALT; cpu_en=0; halted=1; done=0; halt_cause=0; retired=0; key_pulse=0; bp_skip=0.
//  Keys
//   - 2-flop synchroniser, then debounce counter.
//   - Counter clears whenever the synced level equals the accepted level.
//   - Accepted level flips on the DEBOUNCE-th consecutive differing sample.
//   - key_pulse is registered: raw rise -> pulse after 2+DEBOUNCE+1 cycles. Falling edge: no pulse.
//  State machine (cpu_en is a registered output, high exactly in STEP and RUN)
//   - HALT -> RUN on run pulse; HALT -> STEP on step pulse.
//     Both pulses in the same cycle: RUN wins. Leaving HALT sets bp_skip.
//   - STEP: cpu_en=1 for exactly one cycle, then HALT with halt_cause=0.
//     Breakpoint is not checked in STEP; EBREAK/ECALL/limit are.
//   - RUN: stay while cpu_en=1. Exit checks, in priority order:
//     a) limit: step_limit!=0 and retired+1==step_limit -> DONE, cause 3
//     b) ECALL 32'h0000_0073 -> DONE, cause 3
//     c) EBREAK 32'h0010_0073 -> HALT, cause 2
//     d) bp_en and instr_addr==bp_addr and !bp_skip -> HALT, cause 1.
//        This instruction is NOT retired: cpu_en drops in the same cycle through a
//        combinational mask, and it is the only combinational path to cpu_en.
//     e) run pulse -> HALT, cause 0
//   - a/b/c: the triggering instruction retires (counted); the halt takes effect next cycle.
//   - bp_skip clears after the first retired cycle, so resuming from a breakpoint
//     executes it once.
//   - DONE: cpu_en=0; all keys ignored; left only by reset.
//  Counters and flags
//   - retired += 1 on every cycle with effective cpu_en=1; saturates at 2^CNT_W-1.
//   - step_limit is sampled live; changing it while running is legal.
//   - halted is registered and equals (state==HALT || state==DONE).
//   - rst_n asserted mid-RUN drops cpu_en immediately (async); no partial state survives.
// STRUCTURE
//  - rv32i_dbg_defs.vh (shared):
//    state encodings HALT/STEP/RUN/DONE, cause codes, OPC_ECALL, OPC_EBREAK.
//  - Sub-module key_debounce (one per key, generate loop):
//    params DEBOUNCE; ports clk, rst_n, raw, level, rise_pulse.
//  - Top holds the FSM, bp_skip, retired counter and cause register.
// TESTING (DEBOUNCE=4, CNT_W=8)
//  1. Reset then idle 20 cycles -> cpu_en=0, halted=1, retired=0, cause=0.
//  2. key[0] high 10 cycles -> one key_pulse[0] 7 cycles after rise; one cpu_en cycle; retired=1.
//     3-cycle glitch -> no pulse.
//  3. Run; bp_addr=16'h0010, bp_en=1, PC advances by 4 -> halts with PC=0x10 not retired,
//     retired=4, cause=1. Run again -> 0x10 retires, continues.
//  4. step_limit=64, run with NOPs -> done=1 after exactly 64 cpu_en cycles, cause=3, retired=64.
//     Keys are then ignored.
//  5. EBREAK at retire 5 -> retired=6, HALT, cause=2. ECALL -> DONE, cause=3.
//     Step and run pulses in the same cycle -> RUN.
//  6. rst_n low mid-RUN (off clock edge) -> cpu_en=0 at once. All outputs return to reset values.

Source files
------------

// File: rtl/rv32i_run_ctrl_pkg.sv
// Shared definitions for the rv32i debug run controller: FSM states,
// halt cause codes and the two system opcodes that end or pause a run.
package rv32i_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  localparam logic [1:0] CAUSE_KEY    = 2'd0;
  localparam logic [1:0] CAUSE_BP     = 2'd1;
  localparam logic [1:0] CAUSE_EBREAK = 2'd2;
  localparam logic [1:0] CAUSE_END    = 2'd3;

  localparam logic [31:0] OPC_ECALL  = 32'h0000_0073;
  localparam logic [31:0] OPC_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/rv32i_run_ctrl_key_debounce.sv
// One push-button: 2-flop synchroniser, stable-sample debounce counter and a
// registered one-cycle pulse on each accepted rising edge.
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d, level_prev_q, pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) level_d = ~level_q;
      else                             cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pulse_q      <= level_q & ~level_prev_q;
    end
  end

  assign level      = level_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/rv32i_run_ctrl.sv
// Debug run controller: debounced STEP and RUN/HALT keys drive the core
// clock-enable, with breakpoint, EBREAK/ECALL and retire-limit stops.
module rv32i_run_ctrl
  import rv32i_run_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int NKEYS    = 2,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NKEYS-1:0]  key,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic [31:0]       instruction,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [CNT_W-1:0]  step_limit,
  output logic              cpu_en,
  output logic              halted,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  retired,
  output logic [NKEYS-1:0]  key_pulse
);

  logic [NKEYS-1:0] level_w, pulse_w;

  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (key[gi]),
      .level     (level_w[gi]),
      .rise_pulse(pulse_w[gi])
    );
  end

  assign key_pulse = pulse_w & level_w;

  run_state_e       state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic             halted_q, done_q;
  logic             bp_skip_q, bp_skip_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W:0]   ret_inc;
  logic             step_pulse, run_pulse;
  logic             limit_hit, is_ecall, is_ebreak, bp_stop, cpu_en_eff;

  assign step_pulse = key_pulse[0];
  assign run_pulse  = key_pulse[1];
  assign ret_inc    = {1'b0, retired_q} + 1'b1;
  assign limit_hit  = (step_limit != '0) && (ret_inc == {1'b0, step_limit});
  assign is_ecall   = (instruction == OPC_ECALL);
  assign is_ebreak  = (instruction == OPC_EBREAK);

  // A breakpoint hit must not retire, so it masks the registered enable in
  // the same cycle; the higher-priority stops let their instruction retire.
  assign bp_stop    = (state_q == ST_RUN) && bp_en && (instr_addr == bp_addr) &&
                      !bp_skip_q && !limit_hit && !is_ecall && !is_ebreak;
  assign cpu_en_eff = cpu_en_q & ~bp_stop;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    bp_skip_d = bp_skip_q;
    retired_d = retired_q;
    if (cpu_en_eff) begin
      bp_skip_d = 1'b0;
      if (~&retired_q) retired_d = retired_q + 1'b1;
    end
    unique case (state_q)
      ST_HALT: begin
        if (run_pulse) begin
          state_d   = ST_RUN;
          bp_skip_d = 1'b1;
        end else if (step_pulse) begin
          state_d   = ST_STEP;
          bp_skip_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (limit_hit || is_ecall) begin
          state_d = ST_DONE;
          cause_d = CAUSE_END;
        end else if (is_ebreak) begin
          state_d = ST_HALT;
          cause_d = CAUSE_EBREAK;
        end else begin
          state_d = ST_HALT;
          cause_d = CAUSE_KEY;
        end
      end
      ST_RUN: begin
        if (limit_hit || is_ecall) begin
          state_d = ST_DONE;
          cause_d = CAUSE_END;
        end else if (is_ebreak) begin
          state_d = ST_HALT;
          cause_d = CAUSE_EBREAK;
        end else if (bp_stop) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BP;
        end else if (run_pulse) begin
          state_d = ST_HALT;
          cause_d = CAUSE_KEY;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_HALT;
    endcase
    cpu_en_d = (state_d == ST_STEP) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HALT;
      cpu_en_q  <= 1'b0;
      halted_q  <= 1'b1;
      done_q    <= 1'b0;
      bp_skip_q <= 1'b0;
      cause_q   <= CAUSE_KEY;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      halted_q  <= (state_d == ST_HALT) || (state_d == ST_DONE);
      done_q    <= (state_d == ST_DONE);
      bp_skip_q <= bp_skip_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign cpu_en     = cpu_en_eff;
  assign halted     = halted_q;
  assign done       = done_q;
  assign halt_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Randomised bench for rv32i_run_ctrl: a tiny core model steps the PC on
// cpu_en and a program-level reference predicts the outcome of each key press.
module tb_rv32i_run_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  key = 2'b00;
  logic [15:0] instr_addr = '0;
  logic [31:0] instruction = NOP;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = '0;
  logic [7:0]  step_limit = '0;
  logic        cpu_en, halted, done;
  logic [1:0]  halt_cause;
  logic [7:0]  retired;
  logic [1:0]  key_pulse;

  rv32i_run_ctrl #(.ADDR_W(16), .NKEYS(2), .DEBOUNCE(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .instr_addr (instr_addr),
    .instruction(instruction),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .step_limit (step_limit),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .done       (done),
    .halt_cause (halt_cause),
    .retired    (retired),
    .key_pulse  (key_pulse)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int pulse_cnt [2] = '{0, 0};
  int pulse_cyc [2] = '{0, 0};
  logic [31:0] prog [64];
  int core_pc = 0;
  int en_cycles = 0;
  bit en_seen = 1'b0;

  // reference state: PC, retired count, done flag, cause
  int m_pc, m_ret, m_cause;
  bit m_done;

  task automatic check_eq(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (key_pulse[k] === 1'b1) begin
        pulse_cnt[k]++;
        pulse_cyc[k] = cyc;
      end
    end
  end

  // core model: the instruction at core_pc retires on each posedge with cpu_en=1
  initial begin
    forever begin
      @(negedge clk);
      if (en_seen) begin
        core_pc += 4;
        en_cycles++;
      end
      instr_addr  = core_pc[15:0];
      instruction = prog[(core_pc >> 2) & 63];
      #1;
      en_seen = (cpu_en === 1'b1);
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    key = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    core_pc = 0;
    en_seen = 1'b0;
    m_pc = 0; m_ret = 0; m_cause = 0; m_done = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic fill_nops();
    for (int w = 0; w < 64; w++) prog[w] = NOP;
  endtask

  // reference: walk the program from the model PC under the stop rules
  task automatic model_action(input bit is_run);
    bit first = 1'b1;
    logic [31:0] word;
    if (m_done) return;
    for (int guard = 0; guard < 1000; guard++) begin
      word = prog[(m_pc >> 2) & 63];
      if ((step_limit != 0 && m_ret + 1 == int'(step_limit)) || word == ECALL) begin
        m_ret = (m_ret < 255) ? m_ret + 1 : 255;
        m_pc += 4; m_done = 1'b1; m_cause = 3;
        return;
      end
      if (word == EBREAK) begin
        m_ret = (m_ret < 255) ? m_ret + 1 : 255;
        m_pc += 4; m_cause = 2;
        return;
      end
      if (is_run && bp_en && m_pc == int'(bp_addr) && !first) begin
        m_cause = 1;
        return;
      end
      m_ret = (m_ret < 255) ? m_ret + 1 : 255;
      m_pc += 4;
      if (!is_run) begin
        m_cause = 0;
        return;
      end
      first = 1'b0;
    end
  endtask

  task automatic press(input logic [1:0] mask, input int hold, input bit exp_pulse);
    int rise;
    int c0 [2];
    @(negedge clk);
    c0[0] = pulse_cnt[0];
    c0[1] = pulse_cnt[1];
    key  = mask;
    rise = cyc;
    repeat (hold) @(negedge clk);
    key = 2'b00;
    repeat (12) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (mask[k]) begin
        check_eq($sformatf("pulse_count%0d", k), pulse_cnt[k] - c0[k], exp_pulse ? 1 : 0);
        if (exp_pulse) check_eq($sformatf("pulse_delay%0d", k), pulse_cyc[k] - rise, 7);
      end
    end
  endtask

  task automatic wait_halt();
    int n = 0;
    while (halted !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check_eq("halt_timeout", 0, 1);
    repeat (2) @(negedge clk);
    #3;
  endtask

  task automatic do_action(input bit is_run);
    int en0 = en_cycles;
    int ret0 = m_ret;
    model_action(is_run);
    press(is_run ? 2'b10 : 2'b01, 10, 1'b1);
    wait_halt();
    check_eq(is_run ? "run_retired" : "step_retired", int'(retired), m_ret);
    check_eq("cause", int'(halt_cause), m_cause);
    check_eq("done", int'(done), int'(m_done));
    check_eq("halted", int'(halted), 1);
    check_eq("pc", core_pc, m_pc);
    check_eq("en_cycles", en_cycles - en0, m_ret - ret0);
    check_eq("cpu_en_idle", int'(cpu_en), 0);
  endtask

  initial begin
    fill_nops();
    do_reset();
    repeat (20) @(negedge clk);
    check_eq("rst_cpu_en", int'(cpu_en), 0);
    check_eq("rst_halted", int'(halted), 1);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_cause", int'(halt_cause), 0);
    check_eq("rst_retired", int'(retired), 0);
    check_eq("rst_key_pulse", int'(key_pulse), 0);

    // short glitch is rejected by the debouncer
    press(2'b01, 3, 1'b0);
    check_eq("glitch_retired", int'(retired), 0);

    // step, run into breakpoint at 0x10, resume through it to ECALL, then keys ignored
    prog[12] = ECALL;
    bp_en = 1'b1; bp_addr = 16'h0010; step_limit = 8'd0;
    do_action(1'b0);
    do_action(1'b1);
    do_action(1'b1);
    do_action(1'b0);

    // retire limit of 64 over NOPs
    fill_nops();
    bp_en = 1'b0; step_limit = 8'd64;
    do_reset();
    do_action(1'b1);
    do_action(1'b1);

    // EBREAK at word 5 then ECALL at word 8
    fill_nops();
    prog[5] = EBREAK; prog[8] = ECALL;
    step_limit = 8'd0;
    do_reset();
    do_action(1'b1);
    do_action(1'b1);

    // randomised programs, breakpoints, limits and key sequences
    for (int s = 0; s < 12; s++) begin
      for (int w = 0; w < 64; w++) begin
        int r = $urandom_range(0, 23);
        logic [31:0] rnd = $urandom;
        if (r < 2)       prog[w] = EBREAK;
        else if (r == 2) prog[w] = ECALL;
        else             prog[w] = {rnd[31:7], 7'h13};
      end
      for (int w = 40; w < 64; w++) prog[w] = ECALL;
      bp_en      = ($urandom_range(0, 1) == 1);
      bp_addr    = 16'(4 * $urandom_range(0, 20));
      step_limit = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 30)) : 8'd0;
      do_reset();
      for (int a = 0; a < 5; a++) do_action($urandom_range(0, 9) < 6);
    end

    // retired saturates; a run pulse stops a free run with cause 0
    fill_nops();
    bp_en = 1'b0; step_limit = 8'd0;
    do_reset();
    press(2'b10, 10, 1'b1);
    repeat (280) @(negedge clk);
    press(2'b10, 10, 1'b1);
    wait_halt();
    check_eq("sat_retired", int'(retired), 255);
    check_eq("sat_cause", int'(halt_cause), 0);
    check_eq("sat_halted", int'(halted), 1);
    check_eq("sat_done", int'(done), 0);

    // both keys at once enter RUN, then an off-edge reset kills cpu_en at once
    do_reset();
    begin
      int en0 = en_cycles;
      press(2'b11, 10, 1'b1);
      check_eq("both_keys_running", int'(halted), 0);
      check_eq("both_keys_multi_cycle", int'((en_cycles - en0) > 1), 1);
    end
    @(posedge clk);
    #2 check_eq("pre_reset_cpu_en", int'(cpu_en), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_cpu_en", int'(cpu_en), 0);
    check_eq("async_halted", int'(halted), 1);
    check_eq("async_retired", int'(retired), 0);
    check_eq("async_done", int'(done), 0);
    check_eq("async_cause", int'(halt_cause), 0);
    check_eq("async_key_pulse", int'(key_pulse), 0);
    do_reset();
    repeat (5) @(negedge clk);
    check_eq("post_reset_cpu_en", int'(cpu_en), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
